// File: rtl/cpu_bus_serdes.sv
// cpu_bus_serdes: bridge from a wide parallel CPU bus to narrow chip pads.
// Sends address and write data LSB lane first on addr_out/bus_out. For a read it turns
// the bidirectional lane around for one cycle and then shifts read data in from bus_in.
// Optional feature macro: SERDES_WAIT_EN. When it is defined, the pad_rdy input is added
// and a SEND or RECV beat completes only on an edge where pad_rdy is high.
// Every output comes from a flop. Each flop loads the value for the state being entered,
// so the pads see each beat in the same cycle that the FSM is in it.

module cpu_bus_serdes #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              busy,
    output logic [LANE_W-1:0] addr_out,
    output logic [LANE_W-1:0] bus_out,
    input  logic [LANE_W-1:0] bus_in,
    output logic [LANE_W-1:0] bus_oe,
`ifdef SERDES_WAIT_EN
    input  logic              pad_rdy,
`endif
    output logic              pad_frame,
    output logic              pad_we
);

    localparam int unsigned AB   = ADDR_W / LANE_W;
    localparam int unsigned DB   = DATA_W / LANE_W;
    localparam int unsigned SB   = (AB > DB) ? AB : DB;
    localparam int unsigned CntW = $clog2(16) + 1;

    typedef enum logic [2:0] {StIdle, StSend, StTurn, StRecv, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_sr_q, addr_sr_d;
    logic [DATA_W-1:0]   wdata_sr_q, wdata_sr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [LANE_W-1:0]   addr_out_q, addr_out_d;
    logic [LANE_W-1:0]   bus_out_q, bus_out_d;
    logic [LANE_W-1:0]   bus_oe_q, bus_oe_d;
    logic                frame_q, frame_d;
    logic                pad_we_q, pad_we_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;

    logic                beat_done;

`ifdef SERDES_WAIT_EN
    assign beat_done = pad_rdy;
`else
    assign beat_done = 1'b1;
`endif

    // Next-state: sequencing, capture, and shifting of the lane registers.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        addr_sr_d  = addr_sr_q;
        wdata_sr_d = wdata_sr_q;
        we_d       = we_q;
        rx_sr_d    = rx_sr_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    state_d    = StSend;
                    beat_d     = '0;
                    addr_sr_d  = cpu_addr;
                    wdata_sr_d = cpu_wdata;
                    we_d       = cpu_we;
                end
            end
            StSend: begin
                if (beat_done) begin
                    // Shifting right presents the next lane and brings in zeros past the end.
                    addr_sr_d  = addr_sr_q >> LANE_W;
                    wdata_sr_d = wdata_sr_q >> LANE_W;
                    if (beat_q == CntW'(SB - 1)) begin
                        state_d = we_q ? StDone : StTurn;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + CntW'(1);
                    end
                end
            end
            StTurn: begin
                state_d = StRecv;
                beat_d  = '0;
            end
            StRecv: begin
                if (beat_done) begin
                    // Each new lane enters at the top, so the first lane ends up at lane 0.
                    rx_sr_d = rx_sr_q >> LANE_W;
                    rx_sr_d[DATA_W-1 -: LANE_W] = bus_in;
                    if (beat_q == CntW'(DB - 1)) begin
                        state_d = StDone;
                        beat_d  = '0;
                        rdata_d = rx_sr_d;
                    end else begin
                        beat_d = beat_q + CntW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next values, decoded from the state being entered.
    always_comb begin
        addr_out_d = '0;
        bus_out_d  = '0;
        bus_oe_d   = '0;
        frame_d    = 1'b0;
        pad_we_d   = 1'b0;
        busy_d     = (state_d != StIdle);
        ack_d      = (state_d == StDone);
        if (state_d != StIdle) begin
            pad_we_d = we_d;
        end
        if (state_d == StSend) begin
            addr_out_d = addr_sr_d[LANE_W-1:0];
            frame_d    = (beat_d == '0);
            if (we_d) begin
                bus_out_d = wdata_sr_d[LANE_W-1:0];
                bus_oe_d  = {LANE_W{1'b1}};
            end
        end
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            addr_sr_q  <= '0;
            wdata_sr_q <= '0;
            we_q       <= 1'b0;
            rx_sr_q    <= '0;
            rdata_q    <= '0;
            addr_out_q <= '0;
            bus_out_q  <= '0;
            bus_oe_q   <= '0;
            frame_q    <= 1'b0;
            pad_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            addr_sr_q  <= addr_sr_d;
            wdata_sr_q <= wdata_sr_d;
            we_q       <= we_d;
            rx_sr_q    <= rx_sr_d;
            rdata_q    <= rdata_d;
            addr_out_q <= addr_out_d;
            bus_out_q  <= bus_out_d;
            bus_oe_q   <= bus_oe_d;
            frame_q    <= frame_d;
            pad_we_q   <= pad_we_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ack   = ack_q;
    assign busy      = busy_q;
    assign addr_out  = addr_out_q;
    assign bus_out   = bus_out_q;
    assign bus_oe    = bus_oe_q;
    assign pad_frame = frame_q;
    assign pad_we    = pad_we_q;

endmodule

// File: tb/tb_cpu_bus_serdes.sv
// Testbench for cpu_bus_serdes. It runs a default 32/32/8 instance and a 16-bit-address
// instance side by side on the same stimulus. Inputs are driven and outputs are sampled
// on the falling edge. A cycle with "ack seen at edge N" is the cycle that edge N closes.

module tb_cpu_bus_serdes;

    localparam int AB   = 4;
    localparam int DB   = 4;
    localparam int SB   = 4;
    localparam int AB16 = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [7:0]  bus_in;
`ifdef SERDES_WAIT_EN
    logic        pad_rdy;
`endif

    logic [31:0] cpu_rdata, rdata16;
    logic        cpu_ack, ack16, busy, busy16;
    logic [7:0]  addr_out, addr_out16, bus_out, bus_out16, bus_oe, bus_oe16;
    logic        pad_frame, frame16, pad_we, pad_we16;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model_rdata;

    always #5 clk = ~clk;

    cpu_bus_serdes u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .busy      (busy),
        .addr_out  (addr_out),
        .bus_out   (bus_out),
        .bus_in    (bus_in),
        .bus_oe    (bus_oe),
`ifdef SERDES_WAIT_EN
        .pad_rdy   (pad_rdy),
`endif
        .pad_frame (pad_frame),
        .pad_we    (pad_we)
    );

    cpu_bus_serdes #(
        .ADDR_W (16),
        .DATA_W (32),
        .LANE_W (8)
    ) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr[15:0]),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (rdata16),
        .cpu_ack   (ack16),
        .busy      (busy16),
        .addr_out  (addr_out16),
        .bus_out   (bus_out16),
        .bus_in    (bus_in),
        .bus_oe    (bus_oe16),
`ifdef SERDES_WAIT_EN
        .pad_rdy   (pad_rdy),
`endif
        .pad_frame (frame16),
        .pad_we    (pad_we16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Byte lane k of a word, or zero past the last of n lanes.
    function automatic logic [7:0] lane(input logic [31:0] w, input int k, input int n);
        logic [31:0] s;
        s = w >> (8 * k);
        return (k < n) ? s[7:0] : 8'h00;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " ack"}, cpu_ack, 0);
        check({tag, " bus_oe"}, bus_oe, 0);
        check({tag, " addr_out"}, addr_out, 0);
        check({tag, " pad_we"}, pad_we, 0);
        check({tag, " busy16"}, busy16, 0);
    endtask

    // Called on a falling edge with the FSM idle. Presents one request and follows it cycle by
    // cycle to the idle cycle after DONE. With hold=1, cpu_req stays high and the other inputs
    // are scrambled during the transaction. The caller must then start the next transaction
    // straight away, because the idle cycle accepts again.
    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd_word, input bit hold,
                           input logic [31:0] exp_rdata);
        logic [7:0] oe;
        oe = we ? 8'hFF : 8'h00;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; bus_in = 8'($urandom);
        for (int k = 0; k < SB; k++) begin
            @(negedge clk);
            cpu_req = hold; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
            bus_in = 8'($urandom);
            check($sformatf("send%0d addr_out", k), addr_out, lane(addr, k, AB));
            check($sformatf("send%0d bus_out", k), bus_out, we ? lane(wdata, k, DB) : 8'h00);
            check($sformatf("send%0d bus_oe", k), bus_oe, oe);
            check($sformatf("send%0d frame", k), pad_frame, k == 0);
            check($sformatf("send%0d pad_we", k), pad_we, we);
            check($sformatf("send%0d busy", k), busy, 1);
            check($sformatf("send%0d ack", k), cpu_ack, 0);
            check($sformatf("send%0d addr_out16", k), addr_out16, lane(addr, k, AB16));
            check($sformatf("send%0d bus_out16", k), bus_out16, we ? lane(wdata, k, DB) : 8'h00);
            check($sformatf("send%0d bus_oe16", k), bus_oe16, oe);
            check($sformatf("send%0d frame16", k), frame16, k == 0);
            check($sformatf("send%0d pad_we16", k), pad_we16, we);
        end
        if (!we) begin
            @(negedge clk);
            bus_in = 8'($urandom);
            check("turn busy", busy, 1);
            check("turn bus_oe", bus_oe, 0);
            check("turn addr_out", addr_out, 0);
            check("turn ack", cpu_ack, 0);
            for (int j = 0; j < DB; j++) begin
                @(negedge clk);
                bus_in = lane(rd_word, j, DB);
                check($sformatf("recv%0d bus_oe", j), bus_oe, 0);
                check($sformatf("recv%0d addr_out", j), addr_out, 0);
                check($sformatf("recv%0d frame", j), pad_frame, 0);
                check($sformatf("recv%0d ack", j), cpu_ack, 0);
            end
        end
        @(negedge clk);
        bus_in = 8'($urandom);
        check("done ack", cpu_ack, 1);
        check("done rdata", cpu_rdata, exp_rdata);
        check("done busy", busy, 1);
        check("done bus_oe", bus_oe, 0);
        check("done ack16", ack16, 1);
        check("done rdata16", rdata16, exp_rdata);
        @(negedge clk);
        check_quiet("idle");
        check("idle rdata held", cpu_rdata, exp_rdata);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd_word;
        bit          hold;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[6];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 32'hA0B1C2D3, 32'h12345678, 32'h0,        1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h00000010, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 32'h11223344, 32'h55667788, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 32'h00000020, 32'h0,        32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
        tbl[4] = '{1'b1, 32'h0000BEEF, 32'h9ABCDEF0, 32'h0,        1'b0, 32'hCAFEF00D};
        tbl[5] = '{1'b0, 32'hFFFFFFFF, 32'h0,        32'h01020304, 1'b0, 32'h01020304};

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; bus_in = '0;
`ifdef SERDES_WAIT_EN
        pad_rdy = 1'b1;
`endif
        #12;
        check_quiet("reset");
        check("reset rdata", cpu_rdata, 0);
        check("reset frame", pad_frame, 0);
        check("reset bus_out", bus_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rd_word, tbl[i].hold,
                    tbl[i].exp_rdata);
        end
        model_rdata = tbl[5].exp_rdata;

        for (int i = 0; i < 24; i++) begin
            bit          we;
            bit          hold;
            logic [31:0] rd_word;
            we      = 1'($urandom);
            hold    = (i == 23) ? 1'b0 : 1'($urandom);
            rd_word = $urandom;
            if (!we) model_rdata = rd_word;
            run_txn(we, $urandom, $urandom, rd_word, hold, model_rdata);
        end

        // Abort a read in RECV beat 2 with an asynchronous reset.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h00000044;
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (SB + 1 + 2) begin
            @(negedge clk);
            bus_in = 8'($urandom);
        end
        #1 rst_n = 1'b0;
        #1;
        check_quiet("abort");
        check("abort rdata", cpu_rdata, 0);
        check("abort frame", pad_frame, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_rdata = 32'h0;
        repeat (3) begin
            @(negedge clk);
            check("post-abort ack", cpu_ack, 0);
            check("post-abort busy", busy, 0);
        end
        model_rdata = 32'h76543210;
        run_txn(1'b0, 32'h00000044, 32'h0, 32'h76543210, 1'b0, model_rdata);

`ifdef SERDES_WAIT_EN
        // Beat 1 stalls for two edges; ack is then seen at edge 7.
        begin
            logic [7:0] exp_a[7];
            exp_a = '{8'hD3, 8'hC2, 8'hC2, 8'hC2, 8'hB1, 8'hA0, 8'h00};
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hA0B1C2D3; cpu_wdata = 32'h12345678;
            for (int c = 0; c < 7; c++) begin
                @(negedge clk);
                cpu_req = 1'b0;
                pad_rdy = !(c == 1 || c == 2);
                check($sformatf("stall%0d addr_out", c), addr_out, exp_a[c]);
                check($sformatf("stall%0d ack", c), cpu_ack, c == 6);
            end
            pad_rdy = 1'b1;
            @(negedge clk);
            check_quiet("stall idle");
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_bus_serdes.md
Name: cpu_bus_serdes

Overview:
- Parametrised bridge between a wide parallel CPU memory bus and narrow chip pads.
- Serialises address and write data out LSB-lane first, turns the bidirectional lane around, and deserialises read data.
- Next-generation pad interface for the CPU top wrapper. Replaces the fixed 32-bit/8-bit byte sequencer with generic widths, a req/ack handshake, and direction control.

Parameters:
ADDR_W, 32, CPU address width; integer multiple of LANE_W
DATA_W, 32, CPU data width; integer multiple of LANE_W
LANE_W, 8, pad lane width; ADDR_W/LANE_W and DATA_W/LANE_W each between 1 and 16

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
cpu_req  in  1  transaction request, level
cpu_we  in  1  1=write, 0=read; sampled with cpu_req
cpu_addr  in  ADDR_W  address; sampled with cpu_req
cpu_wdata  in  DATA_W  write data; sampled with cpu_req
cpu_rdata  out  DATA_W  read data; valid when cpu_ack pulses on a read, held until next read completes
cpu_ack  out  1  one-cycle completion pulse
busy  out  1  high in every state except IDLE
addr_out  out  LANE_W  dedicated address lane
bus_out  out  LANE_W  bidirectional lane, output value
bus_in  in  LANE_W  bidirectional lane, input value
bus_oe  out  LANE_W  per-bit output enable, 1=drive
pad_frame  out  1  high during the first SEND beat only
pad_we  out  1  registered cpu_we for the current transaction; 0 in IDLE

Behaviour:
- Derived constants: AB=ADDR_W/LANE_W, DB=DATA_W/LANE_W, SB=max(AB,DB). Beat counter width is clog2(16)+1.
- All outputs are registered.
- Reset values:
  - state IDLE, counter 0.
  - All outputs 0, including cpu_rdata, cpu_ack, bus_oe and busy.
  - Capture registers cleared.
- Reset asserted mid-transaction aborts it immediately: no ack, bus_oe=0 at once.
- Edge numbering: edge 0 is the edge at which IDLE samples cpu_req=1.
- IDLE:
  - On cpu_req=1, capture addr, wdata and we, then go to SEND with beat 0.
  - Otherwise stay in IDLE.
- SEND (SB cycles, beat k=0..SB-1):
  - addr_out = addr lane k if k<AB, else 0.
  - Write: bus_out = wdata lane k if k<DB, else 0; bus_oe all ones.
  - Read: bus_out 0, bus_oe 0.
  - pad_frame=1 only for k=0.
  - After the last beat: write goes to DONE, read goes to TURN.
- TURN (1 cycle): bus_oe 0, addr_out 0. Bus turnaround, no sampling.
- RECV (DB cycles):
  - bus_in is sampled on each edge ending a RECV cycle into lane j=0..DB-1 of a shift register, LSB lane first.
  - addr_out 0, bus_oe 0.
- DONE (1 cycle):
  - cpu_ack=1.
  - On a read, cpu_rdata is updated from the shift register in the same edge that enters DONE.
  - Always return to IDLE.
- Latency with defaults: write ack visible after edge SB+1=5; read ack after edge SB+DB+2=10.
- IDLE can accept a new request on the cycle after DONE. A held cpu_req therefore produces back-to-back transactions separated by exactly one IDLE cycle.
- cpu_req/cpu_we/cpu_addr/cpu_wdata are ignored while busy; changes mid-transaction have no effect.
- cpu_rdata is not altered by writes.

Optional Feature:
- Macro: SERDES_WAIT_EN.
- Defined:
  - Adds input port pad_rdy (1 bit).
  - In SEND and RECV, a beat completes only on an edge where pad_rdy=1.
  - While pad_rdy=0, all pad outputs hold and bus_in is not sampled.
  - pad_frame stays high for the whole stalled beat 0.
  - TURN and DONE ignore pad_rdy.
- Undefined: no pad_rdy port; every cycle completes a beat.

Test Plan:
- Write addr=32'hA0B1C2D3, wdata=32'h12345678 -> addr_out D3,C2,B1,A0 and bus_out 78,56,34,12 on consecutive cycles; bus_oe FF throughout; pad_frame only on the first beat; pad_we=1; single cpu_ack after edge 5; busy low afterwards.
- Read addr=32'h00000010; drive bus_in EF,BE,AD,DE in the RECV cycles -> bus_oe 0 from edge 0 onward; cpu_rdata=32'hDEADBEEF with cpu_ack after edge 10; pad_we=0.
- cpu_req held high with a write then a read queued -> exactly one IDLE cycle between transactions; the second transaction uses its values sampled at its own accept edge; cpu_rdata unchanged by the write.
- rst_n pulsed low during RECV beat 2 -> outputs 0 immediately; no ack; the next read completes normally with fresh data.
- ADDR_W=16, DATA_W=32, LANE_W=8, write addr=16'hBEEF -> SEND lasts 4 beats; addr_out EF,BE,00,00; ack after edge 5.
- SERDES_WAIT_EN defined; write with pad_rdy=0 for 2 cycles during beat 1 -> beat 1 values held for 3 cycles; ack delayed to edge 7.
